hidden_layer_seq: RTL
=====================

Name: hidden_layer_seq

Overview:
Time-multiplexed hidden layer that sits directly upstream of the output layer. It streams INPUT_SIZE signed input activations and, on each accepted element, fetches one weight row (HIDDEN_SIZE weights) from an external synchronous ROM. It multiply-accumulates all HIDDEN_SIZE neurons in parallel, then adds bias and applies ReLU. It presents the packed hidden vector plus a one-cycle done pulse that drives the output layer's start.

Parameters:
INPUT_SIZE, 784, number of input elements per inference
HIDDEN_SIZE, 32, number of hidden neurons
DATA_W, 8, signed input/weight width
ACC_W, 24, signed accumulator/bias/output width per neuron
W_ADDR_W, $clog2(INPUT_SIZE), weight ROM address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin inference; sampled only in IDLE
x_in  input  DATA_W  signed input element
x_valid  input  1  x_in valid
x_ready  output  1  block accepts x_in this cycle
w_rd_en  output  1  weight ROM read strobe
w_addr  output  W_ADDR_W  weight row address (= input index)
w_row  input  DATA_W*HIDDEN_SIZE  signed weight row; neuron j at bits [(j+1)*DATA_W-1 -: DATA_W]; valid 1 cycle after w_rd_en
bias_flat  input  ACC_W*HIDDEN_SIZE  signed biases, same packing at ACC_W
hidden_out_flat  output  ACC_W*HIDDEN_SIZE  post-ReLU hidden vector, same packing
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when hidden_out_flat updates
out_valid  output  1  high from done until next accepted start

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; accumulators, element counter and pipeline-valid bit cleared.
- FSM states:
  - IDLE: on start=1, clear accumulators and counter k, clear out_valid, go to LOAD.
  - LOAD: x_ready=1. A beat is accepted on x_valid&x_ready. In the same cycle: w_rd_en=1, w_addr=k, latch x_in into x_reg, set mac_v. After accepting beat k=INPUT_SIZE-1, x_ready drops and the FSM goes to DRAIN.
  - DRAIN: 1 cycle; performs the last MAC; go to BIAS.
  - BIAS: acc[j] += bias[j]; go to OUT.
  - OUT: hidden_out_flat[j] <= (acc[j] < 0) ? 0 : acc[j]; done=1 and out_valid=1 registered together; go to IDLE.
- MAC stage: in the cycle after an accepted beat (mac_v=1), acc[j] += sext(x_reg * w_row[j]). The product is a full 2*DATA_W signed value, sign-extended to ACC_W. Default accumulation and bias addition wrap modulo 2^ACC_W.
- Stalls: x_valid low gives no accept, no w_rd_en, mac_v=0 next cycle, and no accumulator change. Results are independent of gap pattern.
- Latency: done is high in the cycle after the 3rd rising edge following the edge that accepts the last element. With no stalls, total = INPUT_SIZE + 3 cycles from the accept of element 0.
- start while busy is ignored. start held high across IDLE re-entry starts a new inference.
- hidden_out_flat holds its value until the next OUT state; it is not cleared by start.
- Reset mid-operation returns to IDLE immediately; partial results are discarded and outputs are 0.
- w_addr holds its last value when w_rd_en=0.

Optional Feature:
HIDDEN_SAT_EN
- Defined: MAC and bias additions saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow, per neuron, per addition.
- Undefined: two's-complement wrap. Port list is identical in both builds.

Test Plan:
All scenarios use INPUT_SIZE=4, HIDDEN_SIZE=2, DATA_W=8, ACC_W=16.
1. Basic: x=[1,2,3,4], every w_row={w0=1, w1=-1}, bias=[5,5], no stalls -> hidden_out=[15,0]; done one cycle exactly 7 cycles after the first accept; out_valid stays high; w_addr sequence 0,1,2,3.
2. Stalls: same data with x_valid low for 2 cycles between each beat -> hidden_out=[15,0]; exactly 4 w_rd_en pulses; done 3 cycles after the last accept.
3. ReLU/negative: x=[-128,-128,-128,-128], w=[127,-128], bias=[0,0] -> acc0=-65024 wraps to 512, acc1=65536 wraps to 0; out=[512,0] (SAT build: acc0 saturates to -32768, ReLU gives 0; acc1 saturates to 32767; out=[0,32767]).
4. Overflow: x=127 ×4, w=[127,1], bias=[0,-600] -> wrap build out=[0,0] (64516 wraps to -1020; 508-600=-92); SAT build out=[32767,0].
5. Control: start pulsed during LOAD -> ignored, result unchanged. rst_n asserted after 2 beats -> outputs 0, FSM IDLE. A fresh inference then gives the scenario-1 result.

Source files
------------

// File: rtl/hidden_layer_seq.sv
`default_nettype none
// ============================================================================
// Module   : hidden_layer_seq
// Purpose  : Time-multiplexed fully-connected hidden layer. Streams
//            INPUT_SIZE signed activations. Each accepted element fetches
//            one weight row from an external synchronous ROM, and all
//            HIDDEN_SIZE neurons multiply-accumulate in parallel. The layer
//            then adds the bias and applies ReLU. A one-cycle done pulse
//            starts the downstream output layer.
// Ports    : clk, rst_n (async, active-low)
//            start            - begin an inference (honoured only in IDLE)
//            x_in/x_valid/x_ready - activation stream handshake
//            w_rd_en/w_addr   - weight ROM read; w_row valid one cycle later
//            w_row            - packed signed weight row, neuron j at
//                               [(j+1)*DATA_W-1 -: DATA_W]
//            bias_flat        - packed signed biases (ACC_W per neuron)
//            hidden_out_flat  - packed post-ReLU results (ACC_W per neuron)
//            busy, done, out_valid - status
// Options  : `define HIDDEN_SAT_EN -> MAC and bias additions saturate to the
//            signed ACC_W range instead of wrapping. Ports are unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module hidden_layer_seq #(
  parameter int INPUT_SIZE  = 784,
  parameter int HIDDEN_SIZE = 32,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 24,
  parameter int W_ADDR_W    = $clog2(INPUT_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [DATA_W-1:0]             x_in,
  input  logic                          x_valid,
  output logic                          x_ready,
  output logic                          w_rd_en,
  output logic [W_ADDR_W-1:0]           w_addr,
  input  logic [DATA_W*HIDDEN_SIZE-1:0] w_row,
  input  logic [ACC_W*HIDDEN_SIZE-1:0]  bias_flat,
  output logic [ACC_W*HIDDEN_SIZE-1:0]  hidden_out_flat,
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_BIAS  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam logic [W_ADDR_W-1:0] c_last_idx = W_ADDR_W'(INPUT_SIZE - 1);

`ifdef HIDDEN_SAT_EN
  localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // Accumulator addition: wraps by default, clamps on signed overflow when
  // saturation is enabled (overflow = carry-out sign differs from result sign).
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
`ifdef HIDDEN_SAT_EN
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      acc_add = s[ACC_W] ? c_acc_min : c_acc_max;
    else
      acc_add = s[ACC_W-1:0];
`else
    acc_add = a + b;
`endif
  endfunction

  state_t                     r_state;
  logic [W_ADDR_W-1:0]        r_k;
  logic [W_ADDR_W-1:0]        r_addr_hold;
  logic signed [DATA_W-1:0]   r_x;
  logic                       r_mac_v;
  logic                       r_x_ready;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_out_valid;
  logic                       w_accept;

  assign w_accept  = x_valid & r_x_ready;
  assign x_ready   = r_x_ready;
  assign w_rd_en   = w_accept;
  // Address is presented with the accept so the ROM row lines up with the
  // registered activation on the following (MAC) cycle; otherwise it holds.
  assign w_addr    = w_accept ? r_k : r_addr_hold;
  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;

  // --------------------------------------------------------------------------
  // Control FSM and input pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_addr_hold <= '0;
      r_x         <= '0;
      r_mac_v     <= 1'b0;
      r_x_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_mac_v <= w_accept;
      if (w_accept) begin
        r_x         <= x_in;
        r_addr_hold <= r_k;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_x_ready   <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_k == c_last_idx) begin
              r_x_ready <= 1'b0;
              r_state   <= S_DRAIN;
            end else begin
              r_k <= r_k + W_ADDR_W'(1);
            end
          end
        end
        S_DRAIN: r_state <= S_BIAS;   // last MAC completes this cycle
        S_BIAS:  r_state <= S_OUT;
        S_OUT: begin
          r_done      <= 1'b1;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-neuron datapath: MAC, bias and ReLU
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < HIDDEN_SIZE; j++) begin : g_neuron
    logic signed [DATA_W-1:0]   w_wt;
    logic signed [ACC_W-1:0]    w_bias;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_mac_sum;
    logic signed [ACC_W-1:0]    w_bias_sum;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_hid;

    assign w_wt       = w_row[(j+1)*DATA_W-1 -: DATA_W];
    assign w_bias     = bias_flat[(j+1)*ACC_W-1 -: ACC_W];
    assign w_prod     = r_x * w_wt;
    // Signed size cast sign-extends the full-width product into the accumulator.
    assign w_mac_sum  = acc_add(r_acc, ACC_W'(w_prod));
    assign w_bias_sum = acc_add(r_acc, w_bias);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
        r_hid <= '0;
      end else begin
        if (r_state == S_IDLE && start)
          r_acc <= '0;
        else if (r_mac_v)
          r_acc <= w_mac_sum;
        else if (r_state == S_BIAS)
          r_acc <= w_bias_sum;

        if (r_state == S_OUT)
          r_hid <= r_acc[ACC_W-1] ? '0 : r_acc;
      end
    end

    assign hidden_out_flat[(j+1)*ACC_W-1 -: ACC_W] = r_hid;
  end

endmodule
`default_nettype wire
